// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the async FIFO write-side and read-side controllers.
//   depth_of(ptrwidth) : number of RAM entries for a given address width
//   bin2gray(b)        : binary -> reflected Gray code
//   gray2bin(g)        : reflected Gray code -> binary, every bit down to bit 0
// The conversions work on 32-bit vectors. Callers zero-extend their
// (PTRWIDTH+1)-bit pointer and size-cast the result back, so one pair of
// functions serves any pointer width up to 32 bits.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int depth_of(input int ptrwidth);
        return 1 << ptrwidth;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits fold in as zeros, so the result is exact for
    // any narrower pointer.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// STAGES-deep, WIDTH-wide flop chain used to bring a Gray pointer from the
// other clock domain into clk. All stages clear on synchronous reset.
// Ports:
//   clk    in   1       destination clock
//   reset  in   1       synchronous, active-high reset
//   d_i    in   WIDTH   asynchronous input
//   q_o    out  WIDTH   last stage of the chain
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of the async FIFO, wclk domain. Drives the RAM write
// port, publishes a registered Gray write pointer to the read domain, brings
// the read pointer across with a SYNC_STAGES-deep synchroniser, and keeps
// registered full / almost_full / occupancy flags.
//
// Optional feature: define FIFO_WR_OVERFLOW_EN to build the sticky overflow
// flag. Without it overflow is tied 0 and ovf_clr is ignored.
//
// Parameters:
//   PTRWIDTH     address bits, DEPTH = 2**PTRWIDTH
//   SYNC_STAGES  read-pointer synchroniser depth (2..4)
//   AF_THRESH    almost_full threshold on wr_count (1..DEPTH)
// Ports:
//   wclk         in   1            write clock
//   reset        in   1            synchronous, active-high reset
//   push         in   1            write request
//   wr_en        out  1            RAM write enable (combinational)
//   waddr        out  PTRWIDTH     RAM write address
//   wrptr_gray   out  PTRWIDTH+1   registered Gray write pointer
//   rdptr_gray   in   PTRWIDTH+1   Gray read pointer from the read domain
//   full         out  1            registered full flag
//   almost_full  out  1            registered wr_count >= AF_THRESH
//   wr_count     out  PTRWIDTH+1   registered occupancy, 0..DEPTH
//   ovf_clr      in   1            clears the overflow flag
//   overflow     out  1            sticky push-while-full flag
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int PTRWIDTH    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 12
) (
    input  logic                wclk,
    input  logic                reset,
    input  logic                push,
    output logic                wr_en,
    output logic [PTRWIDTH-1:0] waddr,
    output logic [PTRWIDTH:0]   wrptr_gray,
    input  logic [PTRWIDTH:0]   rdptr_gray,
    output logic                full,
    output logic                almost_full,
    output logic [PTRWIDTH:0]   wr_count,
    input  logic                ovf_clr,
    output logic                overflow
);

    localparam int              PW      = PTRWIDTH + 1;
    localparam logic [PTRWIDTH:0] DEPTH_C = PW'(depth_of(PTRWIDTH));
    localparam logic [PTRWIDTH:0] AF_C    = PW'(AF_THRESH);

    logic [PTRWIDTH:0] wrptr_bin_q,  wrptr_bin_d;
    logic [PTRWIDTH:0] wrptr_gray_q, wrptr_gray_d;
    logic [PTRWIDTH:0] wr_count_q,   wr_count_d;
    logic              full_q,       full_d;
    logic              af_q,         af_d;
    logic [PTRWIDTH:0] rd_gray_sync;
    logic [PTRWIDTH:0] rd_bin;
    logic              wr_en_c;

    sync_ff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rdptr_sync (
        .clk    (wclk),
        .reset  (reset),
        .d_i    (rdptr_gray),
        .q_o    (rd_gray_sync)
    );

    // Flags are computed from the post-write pointer against the currently
    // synchronised read pointer; the read pointer is always stale, so full
    // errs on the safe side.
    always_comb begin
        wr_en_c      = push & ~full_q & ~reset;
        wrptr_bin_d  = wrptr_bin_q + {{PTRWIDTH{1'b0}}, wr_en_c};
        wrptr_gray_d = PW'(bin2gray(32'(wrptr_bin_d)));
        rd_bin       = PW'(gray2bin(32'(rd_gray_sync)));
        wr_count_d   = wrptr_bin_d - rd_bin;
        full_d       = (wr_count_d == DEPTH_C);
        af_d         = (wr_count_d >= AF_C);
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            wrptr_bin_q  <= '0;
            wrptr_gray_q <= '0;
            wr_count_q   <= '0;
            full_q       <= 1'b0;
            af_q         <= 1'b0;
        end else begin
            wrptr_bin_q  <= wrptr_bin_d;
            wrptr_gray_q <= wrptr_gray_d;
            wr_count_q   <= wr_count_d;
            full_q       <= full_d;
            af_q         <= af_d;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    logic ovf_q;

    // A new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge wclk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (push & full_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

    assign wr_en       = wr_en_c;
    assign waddr       = wrptr_bin_q[PTRWIDTH-1:0];
    assign wrptr_gray  = wrptr_gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

    localparam int PTRWIDTH = 4;
    localparam int SYNC     = 2;
    localparam int AF       = 12;
    localparam int DEPTH    = 16;
    localparam int PMOD     = 32;

    logic       wclk = 1'b0;
    logic       reset, push, ovf_clr;
    logic [4:0] rdptr_gray;
    logic       wr_en, full, almost_full, overflow;
    logic [3:0] waddr;
    logic [4:0] wrptr_gray, wr_count;

    fifo_wr_ctrl #(
        .PTRWIDTH    (PTRWIDTH),
        .SYNC_STAGES (SYNC),
        .AF_THRESH   (AF)
    ) dut (
        .wclk        (wclk),
        .reset       (reset),
        .push        (push),
        .wr_en       (wr_en),
        .waddr       (waddr),
        .wrptr_gray  (wrptr_gray),
        .rdptr_gray  (rdptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_count    (wr_count),
        .ovf_clr     (ovf_clr),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: occupancy arithmetic on integer pointers, read pointer
    // seen through a fixed delay of SYNC sampled values.
    int m_wptr, m_count, m_rdhist[SYNC];
    bit m_full, m_af, m_ovf;

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        for (int b = 0; b < PMOD; b++) begin
            if (b2g(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_wptr = 0; m_count = 0; m_full = 0; m_af = 0; m_ovf = 0;
        for (int i = 0; i < SYNC; i++) m_rdhist[i] = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int rb;
        if (reset) begin
            model_reset();
            return;
        end
        acc = push && !m_full;
`ifdef FIFO_WR_OVERFLOW_EN
        if (push && m_full) m_ovf = 1;
        else if (ovf_clr)   m_ovf = 0;
`endif
        m_wptr  = (m_wptr + (acc ? 1 : 0)) % PMOD;
        rb      = g2b(m_rdhist[SYNC-1]);
        m_count = (m_wptr - rb + PMOD) % PMOD;
        m_full  = (m_count == DEPTH);
        m_af    = (m_count >= AF);
        for (int i = SYNC - 1; i > 0; i--) m_rdhist[i] = m_rdhist[i-1];
        m_rdhist[0] = int'(rdptr_gray);
    endtask

    // Inputs are already set; checks the combinational port before the edge
    // and every registered output after it.
    task automatic cycle();
        #1;
        check("wr_en", {31'd0, wr_en}, (push && !m_full && !reset) ? 1 : 0);
        check("waddr", {28'd0, waddr}, m_wptr % DEPTH);
        model_edge();
        @(posedge wclk);
        #1;
        check("wrptr_gray",  {27'd0, wrptr_gray}, b2g(m_wptr));
        check("wr_count",    {27'd0, wr_count},   m_count);
        check("full",        {31'd0, full},       m_full);
        check("almost_full", {31'd0, almost_full}, m_af);
        check("overflow",    {31'd0, overflow},   m_ovf);
    endtask

    initial begin
        int af_edge, full_edge, g1, g2, rd_b, full_seen;
        logic [15:0] wmask;
        logic [4:0]  prev_g;
        bit saw_wrap;

        model_reset();
        reset = 1; push = 1; ovf_clr = 0; rdptr_gray = '0;
        @(posedge wclk); #1;

        // 1. reset with push held
        for (int i = 0; i < 2; i++) cycle();
        check("rst_wr_en", {31'd0, wr_en}, 0);

        // 2. fill
        reset = 0; push = 1; af_edge = 0; full_edge = 0; wmask = '0;
        for (int i = 1; i <= 17; i++) begin
            #1;
            if (wr_en) wmask[waddr] = 1'b1;
            cycle();
            if (almost_full && af_edge == 0) af_edge = i;
            if (full && full_edge == 0) full_edge = i;
        end
        check("fill_mask", {16'd0, wmask}, 32'h0000_FFFF);
        check("fill_af_edge", af_edge, 12);
        check("fill_full_edge", full_edge, 16);
        check("fill_gray", {27'd0, wrptr_gray}, 32'h18);
        check("fill_count", {27'd0, wr_count}, 16);

        // 3. release: read pointer jumps to 4
        push = 0; rdptr_gray = 5'b00110;
        cycle(); check("rel_full_e1", {31'd0, full}, 1);
        cycle(); check("rel_full_e2", {31'd0, full}, 1);
        cycle(); check("rel_full_e3", {31'd0, full}, 0);
        check("rel_count", {27'd0, wr_count}, 12);
        check("rel_af", {31'd0, almost_full}, 1);

        // 4. wrap with the read pointer trailing by two cycles
        push = 1; g1 = b2g(m_wptr); g2 = g1; saw_wrap = 0; full_seen = 0;
        prev_g = wrptr_gray;
        for (int i = 0; i < 40; i++) begin
            rdptr_gray = 5'(g2);
            cycle();
            if (prev_g == 5'b10000 && wrptr_gray == 5'b00000) saw_wrap = 1;
            if (full) full_seen++;
            prev_g = wrptr_gray;
            g2 = g1; g1 = b2g(m_wptr);
        end
        check("wrap_seen", {31'd0, saw_wrap}, 1);
        check("wrap_no_full", full_seen, 0);

        // 5. overflow: freeze reader, fill past full, then clear
        push = 0; rdptr_gray = 5'(b2g(m_wptr));
        for (int i = 0; i < 3; i++) cycle();
        push = 1;
        for (int i = 0; i < 20; i++) cycle();
        check("ovf_full", {31'd0, full}, 1);
`ifdef FIFO_WR_OVERFLOW_EN
        check("ovf_set", {31'd0, overflow}, 1);
`else
        check("ovf_off", {31'd0, overflow}, 0);
`endif
        push = 0; ovf_clr = 1; cycle();
        ovf_clr = 0; cycle();
        check("ovf_clr", {31'd0, overflow}, 0);

        // 6. reset mid-fill
        reset = 1; rdptr_gray = '0; cycle();
        reset = 0; push = 1;
        for (int i = 0; i < 7; i++) cycle();
        check("mid_count", {27'd0, wr_count}, 7);
        reset = 1; cycle();
        check("mid_rst_gray", {27'd0, wrptr_gray}, 0);
        check("mid_rst_count", {27'd0, wr_count}, 0);
        check("mid_rst_flags", {29'd0, full, almost_full, overflow}, 0);
        reset = 0; push = 1; #1;
        check("mid_waddr", {28'd0, waddr}, 0);
        check("mid_wr_en", {31'd0, wr_en}, 1);
        cycle();

        // random traffic; reader never passes the writer
        reset = 1; push = 0; rdptr_gray = '0; cycle();
        rd_b = 0;
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            push    = ($urandom_range(0, 99) < 65);
            ovf_clr = ($urandom_range(0, 9) == 0);
            if (reset) rd_b = 0;
            else if (rd_b != m_wptr && $urandom_range(0, 1) == 1) rd_b = (rd_b + 1) % PMOD;
            rdptr_gray = 5'(b2g(rd_b));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
